// File: rtl/eq_band_sched.sv
// eq_band_sched: time-shares one FIR MAC between the LF and HF sample queues, one band job at a time.
// Build macro EQ_SCHED_FIXED_PRIO_EN selects fixed LF-first priority instead of round-robin.
module eq_band_sched #(
    parameter int unsigned TAPS = 1021,
    parameter int unsigned AW   = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lf_req,
    input  logic          hf_req,
    output logic          lf_gnt,
    output logic          hf_gnt,
    output logic          lf_seq,
    output logic          hf_seq,
    output logic          band_sel,
    output logic [AW-1:0] coeff_addr,
    output logic          clr_acc,
    output logic          acc_en,
    output logic          res_vld,
    output logic          ovf_lf,
    output logic          ovf_hf
);

    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_pend_lf;
    logic          r_pend_hf;
    logic          r_ovf_lf;
    logic          r_ovf_hf;
    logic          r_band;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_tap;
    logic          r_lf_gnt;
    logic          r_hf_gnt;
    logic          r_lf_seq;
    logic          r_hf_seq;
    logic          r_clr_acc;
    logic          r_acc_en;
    logic          r_res_vld;

    logic          w_pick_hf;
    logic          w_gnt_lf;
    logic          w_gnt_hf;
    logic          w_band_nxt;
    logic [AW-1:0] w_addr_nxt;
    logic [AW-1:0] w_tap_nxt;
    logic          w_clr_nxt;
    logic          w_seq_nxt;
    logic          w_res_nxt;

    // Arbitration between pending bands
`ifdef EQ_SCHED_FIXED_PRIO_EN
    assign w_pick_hf = r_pend_hf & ~r_pend_lf;
`else
    logic r_last_hf;

    // Band served most recently; reset favours LF on the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_hf <= 1'b1;
        end else if (r_state == S_DONE) begin
            r_last_hf <= r_band;
        end
    end

    assign w_pick_hf = r_pend_hf & (~r_pend_lf | ~r_last_hf);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; r_tap runs one cycle ahead of coeff_addr
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_lf    = 1'b0;
        w_gnt_hf    = 1'b0;
        w_band_nxt  = r_band;
        w_addr_nxt  = r_addr;
        w_tap_nxt   = r_tap;
        w_clr_nxt   = 1'b0;
        w_seq_nxt   = 1'b0;
        w_res_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_pend_lf || r_pend_hf) begin
                    w_gnt_hf    = w_pick_hf;
                    w_gnt_lf    = ~w_pick_hf;
                    w_band_nxt  = w_pick_hf;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_clr_nxt   = 1'b1;
                w_addr_nxt  = '0;
                w_tap_nxt   = '0;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_seq_nxt  = 1'b1;
                w_addr_nxt = r_tap;
                w_tap_nxt  = r_tap + AW'(1);
                if (r_tap == LAST_TAP) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_res_nxt   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request capture, overflow tracking and registered job outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_lf <= 1'b0;
            r_pend_hf <= 1'b0;
            r_ovf_lf  <= 1'b0;
            r_ovf_hf  <= 1'b0;
            r_band    <= 1'b0;
            r_addr    <= '0;
            r_tap     <= '0;
            r_lf_gnt  <= 1'b0;
            r_hf_gnt  <= 1'b0;
            r_lf_seq  <= 1'b0;
            r_hf_seq  <= 1'b0;
            r_clr_acc <= 1'b0;
            r_acc_en  <= 1'b0;
            r_res_vld <= 1'b0;
        end else begin
            r_pend_lf <= (r_pend_lf & ~w_gnt_lf) | lf_req;
            r_pend_hf <= (r_pend_hf & ~w_gnt_hf) | hf_req;
            r_ovf_lf  <= r_ovf_lf | (lf_req & r_pend_lf & ~w_gnt_lf);
            r_ovf_hf  <= r_ovf_hf | (hf_req & r_pend_hf & ~w_gnt_hf);
            r_band    <= w_band_nxt;
            r_addr    <= w_addr_nxt;
            r_tap     <= w_tap_nxt;
            r_lf_gnt  <= w_gnt_lf;
            r_hf_gnt  <= w_gnt_hf;
            r_lf_seq  <= w_seq_nxt & ~w_band_nxt;
            r_hf_seq  <= w_seq_nxt & w_band_nxt;
            r_clr_acc <= w_clr_nxt;
            r_acc_en  <= r_lf_seq | r_hf_seq;
            r_res_vld <= w_res_nxt;
        end
    end

    assign lf_gnt     = r_lf_gnt;
    assign hf_gnt     = r_hf_gnt;
    assign lf_seq     = r_lf_seq;
    assign hf_seq     = r_hf_seq;
    assign band_sel   = r_band;
    assign coeff_addr = r_addr;
    assign clr_acc    = r_clr_acc;
    assign acc_en     = r_acc_en;
    assign res_vld    = r_res_vld;
    assign ovf_lf     = r_ovf_lf;
    assign ovf_hf     = r_ovf_hf;

endmodule

// File: tb/tb_eq_band_sched.sv
// tb_eq_band_sched: job-level reference model checked every cycle, plus hand-computed timing pins.
module tb_eq_band_sched;

    localparam int TAPS = 8;
    localparam int AW   = 4;
    localparam int NOUT = 10 + AW;

    logic          clk;
    logic          rst_n;
    logic          lf_req;
    logic          hf_req;
    logic          lf_gnt;
    logic          hf_gnt;
    logic          lf_seq;
    logic          hf_seq;
    logic          band_sel;
    logic [AW-1:0] coeff_addr;
    logic          clr_acc;
    logic          acc_en;
    logic          res_vld;
    logic          ovf_lf;
    logic          ovf_hf;

    eq_band_sched #(.TAPS(TAPS), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lf_req     (lf_req),
        .hf_req     (hf_req),
        .lf_gnt     (lf_gnt),
        .hf_gnt     (hf_gnt),
        .lf_seq     (lf_seq),
        .hf_seq     (hf_seq),
        .band_sel   (band_sel),
        .coeff_addr (coeff_addr),
        .clr_acc    (clr_acc),
        .acc_en     (acc_en),
        .res_vld    (res_vld),
        .ovf_lf     (ovf_lf),
        .ovf_hf     (ovf_hf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: a job is a start cycle plus a band; all outputs follow from the offset into the job
    int            cyc = 0;
    logic          m_job = 1'b0;
    int            m_g = 0;
    logic          m_band = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic          m_pend_lf = 1'b0;
    logic          m_pend_hf = 1'b0;
    logic          m_ovf_lf = 1'b0;
    logic          m_ovf_hf = 1'b0;
    logic          m_last_hf = 1'b1;

    always @(posedge clk) begin
        int   e;
        int   off;
        logic busy;
        logic gl;
        logic gh;
        e = cyc + 1;
        if (!rst_n) begin
            m_job     <= 1'b0;
            m_band    <= 1'b0;
            m_addr    <= '0;
            m_pend_lf <= 1'b0;
            m_pend_hf <= 1'b0;
            m_ovf_lf  <= 1'b0;
            m_ovf_hf  <= 1'b0;
            m_last_hf <= 1'b1;
        end else begin
            off  = e - m_g;
            busy = m_job && (off <= TAPS + 3);
            gl   = 1'b0;
            gh   = 1'b0;
            if (!busy && (m_pend_lf || m_pend_hf)) begin
`ifdef EQ_SCHED_FIXED_PRIO_EN
                gh = m_pend_hf && !m_pend_lf;
`else
                gh = m_pend_hf && (!m_pend_lf || !m_last_hf);
`endif
                gl = !gh;
                m_job  <= 1'b1;
                m_g    <= e;
                m_band <= gh;
            end
            m_pend_lf <= (m_pend_lf && !gl) || lf_req;
            m_pend_hf <= (m_pend_hf && !gh) || hf_req;
            m_ovf_lf  <= m_ovf_lf || (lf_req && m_pend_lf && !gl);
            m_ovf_hf  <= m_ovf_hf || (hf_req && m_pend_hf && !gh);
            if (busy) begin
                if (off == 1) m_addr <= '0;
                if (off >= 2 && off <= TAPS + 1) m_addr <= AW'(off - 2);
                if (off == TAPS + 3) m_last_hf <= m_band;
            end
        end
        cyc <= e;
    end

    function automatic logic [NOUT-1:0] model_outs();
        int   off;
        logic act;
        logic seq;
        off = cyc - m_g;
        act = m_job && (off <= TAPS + 3);
        seq = act && off >= 2 && off <= TAPS + 1;
        return {act && off == 0 && !m_band, act && off == 0 && m_band,
                seq && !m_band, seq && m_band, m_band, m_addr,
                act && off == 1, act && off >= 3 && off <= TAPS + 2,
                act && off == TAPS + 3, m_ovf_lf, m_ovf_hf};
    endfunction

    logic [NOUT-1:0] dut_outs;
    assign dut_outs = {lf_gnt, hf_gnt, lf_seq, hf_seq, band_sel, coeff_addr,
                       clr_acc, acc_en, res_vld, ovf_lf, ovf_hf};

    // Event log for the literal timing pins
    int   t_lf_gnt = -1;
    int   t_hf_gnt = -1;
    int   t_res = -1;
    logic res_band = 1'b0;
    int   n_lf_gnt = 0;
    int   n_acc = 0;

    always @(negedge clk) begin
        logic [NOUT-1:0] ex;
        if (cyc > 0) begin
            ex = model_outs();
            n_vec++;
            if (dut_outs !== ex) begin
                n_bad++;
                $display("FAIL outs cyc=%0d got=%b exp=%b", cyc, dut_outs, ex);
            end
            if (lf_gnt) begin t_lf_gnt = cyc; n_lf_gnt++; end
            if (hf_gnt) t_hf_gnt = cyc;
            if (acc_en) n_acc++;
            if (res_vld) begin t_res = cyc; res_band = band_sel; end
        end
    end

    task automatic check_eq(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic pulse(input logic l, input logic h);
        lf_req = l;
        hf_req = h;
        @(negedge clk);
        lf_req = 1'b0;
        hf_req = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_outs", int'(dut_outs), 0);
        rst_n = 1'b1;
    endtask

    int t0;
    int nl;
    int na;

    initial begin
        rst_n  = 1'b0;
        lf_req = 1'b0;
        hf_req = 1'b0;
        @(negedge clk);
        apply_reset();

        // Single LF job
        pulse(1'b1, 1'b0);
        t0 = cyc;
        na = n_acc;
        repeat (16) @(negedge clk);
        check_eq("s1_lf_gnt", t_lf_gnt - t0, 1);
        check_eq("s1_res", t_res - t0, 12);
        check_eq("s1_acc_cnt", n_acc - na, 8);
        check_eq("s1_res_band", int'(res_band), 0);
        check_eq("s1_no_hf", t_hf_gnt, -1);

        // Simultaneous requests from reset: LF first
        apply_reset();
        pulse(1'b1, 1'b1);
        t0 = cyc;
        repeat (30) @(negedge clk);
        check_eq("s2_lf_gnt", t_lf_gnt - t0, 1);
        check_eq("s2_hf_gnt", t_hf_gnt - t0, 13);
        check_eq("s2_res", t_res - t0, 24);
        check_eq("s2_res_band", int'(res_band), 1);

        // LF alone, then a tie: round-robin favours HF
        pulse(1'b1, 1'b0);
        repeat (15) @(negedge clk);
        pulse(1'b1, 1'b1);
        t0 = cyc;
        repeat (30) @(negedge clk);
`ifdef EQ_SCHED_FIXED_PRIO_EN
        check_eq("s3_lf_gnt", t_lf_gnt - t0, 1);
        check_eq("s3_hf_gnt", t_hf_gnt - t0, 13);
`else
        check_eq("s3_hf_gnt", t_hf_gnt - t0, 1);
        check_eq("s3_lf_gnt", t_lf_gnt - t0, 13);
`endif

        // HF request during an LF job waits, no overflow
        pulse(1'b1, 1'b0);
        t0 = cyc;
        repeat (4) @(negedge clk);
        pulse(1'b0, 1'b1);
        repeat (30) @(negedge clk);
        check_eq("s4_hf_gnt", t_hf_gnt - t0, 13);
        check_eq("s4_ovf_hf", int'(ovf_hf), 0);

        // Two LF requests during an HF job: overflow, one extra LF job
        pulse(1'b0, 1'b1);
        nl = n_lf_gnt;
        repeat (3) @(negedge clk);
        pulse(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        pulse(1'b1, 1'b0);
        repeat (30) @(negedge clk);
        check_eq("s5_ovf_lf", int'(ovf_lf), 1);
        check_eq("s5_lf_jobs", n_lf_gnt - nl, 1);
        repeat (5) @(negedge clk);
        check_eq("s5_ovf_sticky", int'(ovf_lf), 1);

        // Reset mid-RUN at coeff_addr 3, then a clean job
        pulse(1'b1, 1'b0);
        repeat (6) @(negedge clk);
        check_eq("s6_addr3", int'(coeff_addr), 3);
        check_eq("s6_seq", int'(lf_seq), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("s6_rst_outs", int'(dut_outs), 0);
        rst_n = 1'b1;
        na = n_acc;
        pulse(1'b1, 1'b0);
        t0 = cyc;
        repeat (16) @(negedge clk);
        check_eq("s6_lf_gnt", t_lf_gnt - t0, 1);
        check_eq("s6_job_len", t_res - t_lf_gnt, 11);
        check_eq("s6_acc_cnt", n_acc - na, 8);

        // Request on the cycle of its own grant keeps pending without overflow
        nl = n_lf_gnt;
        pulse(1'b1, 1'b0);
        t0 = cyc;
        pulse(1'b1, 1'b0);
        repeat (30) @(negedge clk);
        check_eq("s7_lf_jobs", n_lf_gnt - nl, 2);
        check_eq("s7_second_gnt", t_lf_gnt - t0, 13);
        check_eq("s7_ovf_lf", int'(ovf_lf), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
